// File: rtl/crc7_encode.sv
// Bit-serial CRC-7 encoder, G(x)=x^7+x^3+1, one payload bit per clock MSB first.
// Optional build macro CRC7_ERR_INJ_EN adds err_inj to corrupt code_out[0] of a frame.
module crc7_encode #(
  parameter int                 DATA_W = 16,
  parameter int                 CRC_W  = 7,
  parameter logic [CRC_W-1:0]   POLY   = 7'h09
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         data_in,
`ifdef CRC7_ERR_INJ_EN
  input  logic                      err_inj,
`endif
  output logic [DATA_W+CRC_W-1:0]   code_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   shift_reg;
  logic [DATA_W-1:0]   payload_reg;
  logic [CRC_W-1:0]    crc_reg;
  logic [CRC_W-1:0]    crc_next;
  logic [CNT_W-1:0]    cnt;
  logic                fb;
  logic                last_bit;
  logic [CRC_W-1:0]    crc_flip;
`ifdef CRC7_ERR_INJ_EN
  logic                inj_reg;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = !in_ready;
  assign last_bit = (cnt == CNT_W'(DATA_W - 1));

  // One LFSR step: feedback is the outgoing CRC MSB xor the incoming payload bit.
  assign fb       = crc_reg[CRC_W-1] ^ shift_reg[DATA_W-1];
  assign crc_next = {crc_reg[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

`ifdef CRC7_ERR_INJ_EN
  assign crc_flip = {{(CRC_W-1){1'b0}}, inj_reg};
`else
  assign crc_flip = '0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_reg   <= '0;
      payload_reg <= '0;
      crc_reg     <= '0;
      cnt         <= '0;
      code_out    <= '0;
      out_valid   <= 1'b0;
`ifdef CRC7_ERR_INJ_EN
      inj_reg     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg   <= data_in;
            payload_reg <= data_in;
            crc_reg     <= '0;
            cnt         <= '0;
`ifdef CRC7_ERR_INJ_EN
            inj_reg     <= err_inj;
`endif
          end
        end
        SHIFT: begin
          crc_reg   <= crc_next;
          shift_reg <= shift_reg << 1;
          // The final step's remainder is taken straight from crc_next into the codeword.
          if (last_bit) begin
            code_out  <= {payload_reg, crc_next ^ crc_flip};
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc7_encode.sv
// Scoreboard bench for crc7_encode: expected codewords are queued at accept and
// compared when out_valid rises; covers reset, latency, stall in DONE and mid-frame reset.
module tb_crc7_encode;

  localparam int DATA_W = 16;
  localparam int CRC_W  = 7;
  localparam int CW_W   = DATA_W + CRC_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              err_inj;
  logic [CW_W-1:0]   code_out;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  logic [CW_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  crc7_encode dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
`ifdef CRC7_ERR_INJ_EN
    .err_inj   (err_inj),
`endif
    .code_out  (code_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Reference: long division of payload*x^7 by the full generator 8'h89.
  function automatic logic [CW_W-1:0] model(input logic [DATA_W-1:0] d, input logic inj);
    logic [CW_W-1:0] m;
    m = {d, {CRC_W{1'b0}}};
    for (int i = CW_W - 1; i >= CRC_W; i--)
      if (m[i]) m = m ^ (CW_W'(8'h89) << (i - CRC_W));
    return {d, m[CRC_W-1:0] ^ {{(CRC_W-1){1'b0}}, inj}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one payload; the accept edge is the tick() inside.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic inj, input bit push);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    data_in  = d;
    err_inj  = inj;
    if (push) exp_q.push_back(model(d, inj));
    tick();
    in_valid = 1'b0;
    data_in  = DATA_W'($urandom);
    err_inj  = 1'b0;
  endtask

  // Waits (bounded) for out_valid, pops the scoreboard and checks code and latency.
  task automatic collect(input string name, input bit check_handoff);
    int lat = 0;
    logic [CW_W-1:0] exp_cw;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    exp_cw = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, lat);
      return;
    end
    checks++;
    if (code_out !== exp_cw) begin
      failures++;
      $display("FAIL %s_code: code_out=%h required %h", name, code_out, exp_cw);
    end
    checks++;
    if (lat != DATA_W) begin
      failures++;
      $display("FAIL %s_latency: latency=%0d required %0d", name, lat, DATA_W);
    end
    if (check_handoff) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_handoff: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                 name, out_valid, in_ready, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; data_in = 16'hBEEF; out_ready = 1'b0; err_inj = 1'b0;
    tick(); tick();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++;
    if (code_out !== '0) begin failures++; $display("FAIL reset_code_out: got %h required 0", code_out); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_vectors();
    logic [DATA_W-1:0] vec [4] = '{16'h0001, 16'h8000, 16'h8001, 16'h0000};
    out_ready = 1'b1;
    foreach (vec[i]) begin
      send_frame(vec[i], 1'b0, 1'b1);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL vec_busy: got %b required 1", busy); end
      collect($sformatf("vec%0d", i), 1'b1);
    end
  endtask

  task automatic test_hold();
    logic [CW_W-1:0] exp_cw;
    out_ready = 1'b0;
    send_frame(16'hA5C3, 1'b0, 1'b1);
    exp_cw = model(16'hA5C3, 1'b0);
    collect("hold", 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      data_in  = DATA_W'($urandom);
      out_ready = $urandom_range(0, 1) == 0 ? 1'b0 : 1'b0;
      tick();
      checks++;
      if (code_out !== exp_cw || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable%0d: code_out=%h out_valid=%b in_ready=%b required %h 1 0",
                 i, code_out, out_valid, in_ready, exp_cw);
      end
    end
    // Handoff with in_valid high: only the handoff happens this edge.
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_handoff: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || code_out !== exp_cw) begin
      failures++;
      $display("FAIL hold_no_accept: in_ready=%b code_out=%h required 1 %h", in_ready, code_out, exp_cw);
    end
  endtask

  task automatic test_reset_mid();
    bit rose = 1'b0;
    out_ready = 1'b1;
    send_frame(16'h1234, 1'b0, 1'b0);
    repeat (8) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || code_out !== '0) begin
      failures++;
      $display("FAIL midreset_state: in_ready=%b busy=%b out_valid=%b code_out=%h required 1 0 0 0",
               in_ready, busy, out_valid, code_out);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid === 1'b1) rose = 1'b1;
    end
    checks++;
    if (rose) begin failures++; $display("FAIL midreset_dropped: out_valid rose=1 required 0"); end
    send_frame(16'h0001, 1'b0, 1'b1);
    collect("midreset_next", 1'b1);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_frame(DATA_W'($urandom), 1'b0, 1'b1);
      collect($sformatf("b2b%0d", i), 1'b1);
    end
  endtask

`ifdef CRC7_ERR_INJ_EN
  task automatic test_err_inj();
    out_ready = 1'b1;
    send_frame(16'h0001, 1'b1, 1'b1);
    collect("errinj", 1'b1);
    send_frame(16'h0001, 1'b0, 1'b1);
    collect("errinj_clean", 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_reset_mid();
    test_back_to_back();
`ifdef CRC7_ERR_INJ_EN
    test_err_inj();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
